imem_fetch_sequencer: RTL and testbench
=======================================

# imem_fetch_sequencer

Front-end sequencer for the execution engine: fetches 32-bit instructions from the instruction memory over the shared 16-bit address bus, decodes their fields, and hands them one at a time to the execution engine with a valid/ready handshake. It owns the program counter and the instruction-memory read strobe. It halts on the Stop opcode (FFh) and flags illegal opcodes and run-off past the end of the program.

## Interface
Parameters:
- IMEM_SEL, 4'h8, value driven on address[15:12] to select instruction memory
- IMEM_DEPTH, 10, number of valid instruction words; PC range 0..IMEM_DEPTH-1

Ports:
- Clk  in  1  clock; all logic on posedge
- nReset  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begin fetching at PC 0 (honoured in IDLE, HALT, ERROR)
- abort  in  1  return to IDLE at next edge from any state
- address  out  16  {IMEM_SEL, 12'(pc)} while nRead low, else 16'h0000
- nRead  out  1  active-low read strobe to instruction memory
- DataIn  in  256  instruction memory DataOut; instruction in bits [31:0]
- instr_valid  out  1  decoded instruction available
- instr_ready  in  1  engine accepts instruction when valid & ready
- opcode, dest, src1, src2  out  8 each  fields [31:24], [23:16], [15:8], [7:0]
- is_matrix  out  1  opcode in 00h–05h
- pc_out  out  12  PC of the instruction currently presented
- busy / done / err  out  1 each  running / halted on Stop / illegal opcode or run-off

## Operation
- States: IDLE, REQ, WAIT, PRESENT, HALT, ERROR.
- IDLE: nRead=1; on start go to REQ with pc=0.
- REQ: nRead=0 and address valid for exactly one cycle; then WAIT.
- WAIT: memory output settles; at the end of WAIT, latch DataIn[31:0] into the instruction register and decode it:
  - FFh → HALT, done=1; Stop is never presented.
  - 00h–05h or 10h–13h → PRESENT.
  - Any other opcode → ERROR, err=1.
- PRESENT: instr_valid=1; fields stable until handshake.
  - On valid & ready: if pc == IMEM_DEPTH-1, go to ERROR (run-off); else pc+1, go to REQ.
- HALT / ERROR: sticky; only start (→ REQ, pc=0, flags cleared), abort, or reset exits. done and err are never both 1.
- abort has priority over start and over handshake in the same cycle; the instruction is dropped and pc=0.
- busy = 1 in REQ, WAIT, PRESENT.
- PC is 12 bits, never wraps; run-off is an error, not a wrap to 0.

## Timing
- Reset (nReset low at posedge): state IDLE, pc=0, nRead=1, address=0, instr_valid=0, opcode/dest/src1/src2=0, is_matrix=0, pc_out=0, busy=0, done=0, err=0. Reset mid-fetch discards the fetch; an nRead already issued completes harmlessly.
- All outputs are registered.
- Start sampled at edge E0: REQ during E0–E1; WAIT during E1–E2; instr_valid=1 from E2.
- Back-to-back fetch rate with ready tied high is one instruction per 3 cycles: handshake at edge Ek, nRead low during Ek–Ek+1, next valid at Ek+2.
- instr_valid is held with ready low indefinitely; no refetch occurs.
- nRead is never low for two consecutive cycles.

## Structure
- Shared package (isa_pkg): opcode constants (MMULT 00h … MSCALEIMM 05h, INTADD 10h … INTDIV 13h, STOP FFh), unit select constants for address[15:12], state enum, function is_legal_opcode().
- Single module; no sub-module required. The decode is a small function from the package.

## Test plan
- Program {01_02_00_01, 02_03_00_01, FF_FF_FF_FF}, ready tied high → three nRead pulses at addresses 8000h, 8001h, 8002h; two instructions presented (opcode 01h dest 02h, then 02h dest 03h); done=1 and pc_out=1 at halt.
- Same program, ready held low for 5 cycles on the first instruction → fields stable for 5 cycles, no extra nRead, then normal continuation.
- Word 0 = 07_00_00_00 → err=1 and no instr_valid. A later start clears err and refetches from 8000h.
- IMEM_DEPTH=2, no Stop in the program → second handshake goes to ERROR; address 8002h is never driven.
- abort asserted in WAIT with start also high → IDLE next cycle, pc=0, nRead=1, instr_valid=0.
- nReset low during PRESENT → all outputs at reset values on the next edge; start after release fetches 8000h.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction-fetch front end: opcodes, unit selects,
// sequencer states and the opcode legality decode.
package isa_pkg;

    localparam logic [7:0] OP_MMULT     = 8'h00;
    localparam logic [7:0] OP_MADD      = 8'h01;
    localparam logic [7:0] OP_MSUB      = 8'h02;
    localparam logic [7:0] OP_MTRANS    = 8'h03;
    localparam logic [7:0] OP_MSCALE    = 8'h04;
    localparam logic [7:0] OP_MSCALEIMM = 8'h05;
    localparam logic [7:0] OP_INTADD    = 8'h10;
    localparam logic [7:0] OP_INTSUB    = 8'h11;
    localparam logic [7:0] OP_INTMUL    = 8'h12;
    localparam logic [7:0] OP_INTDIV    = 8'h13;
    localparam logic [7:0] OP_STOP      = 8'hFF;

    // address[15:12] unit selects on the shared bus
    localparam logic [3:0] UNIT_NONE = 4'h0;
    localparam logic [3:0] UNIT_IMEM = 4'h8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_PRESENT,
        ST_HALT,
        ST_ERROR
    } state_t;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src2;
    } instr_t;

    function automatic logic is_matrix_opcode(input logic [7:0] op);
        return op <= OP_MSCALEIMM;
    endfunction

    function automatic logic is_legal_opcode(input logic [7:0] op);
        return is_matrix_opcode(op) || (op >= OP_INTADD && op <= OP_INTDIV);
    endfunction

endpackage

// File: rtl/imem_fetch_sequencer.sv
// Fetches 32-bit instructions from instruction memory one at a time, decodes the
// fields and presents them to the execution engine over a valid/ready handshake.
module imem_fetch_sequencer
    import isa_pkg::*;
#(
    parameter logic [3:0] IMEM_SEL   = UNIT_IMEM,
    parameter int         IMEM_DEPTH = 10
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         start,
    input  logic         abort,
    output logic [15:0]  address,
    output logic         nRead,
    input  logic [255:0] DataIn,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [7:0]   opcode,
    output logic [7:0]   dest,
    output logic [7:0]   src1,
    output logic [7:0]   src2,
    output logic         is_matrix,
    output logic [11:0]  pc_out,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [11:0] LAST_PC = 12'(IMEM_DEPTH - 1);

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic        nread_q, nread_d;
    logic [15:0] address_q, address_d;
    logic        valid_q, valid_d;
    instr_t      instr_q, instr_d;
    logic        is_matrix_q, is_matrix_d;
    logic [11:0] pc_out_q, pc_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    instr_t      fetched;
    logic        unused_datain;

    assign fetched       = instr_t'(DataIn[31:0]);
    assign unused_datain = ^DataIn[255:32];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        nread_d     = nread_q;
        address_d   = address_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        is_matrix_d = is_matrix_q;
        pc_out_d    = pc_out_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;

        // abort beats start and handshake; any presented instruction is dropped
        if (abort) begin
            state_d   = ST_IDLE;
            pc_d      = '0;
            nread_d   = 1'b1;
            address_d = '0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALT, ST_ERROR: begin
                    if (start) begin
                        state_d   = ST_REQ;
                        pc_d      = '0;
                        nread_d   = 1'b0;
                        address_d = {IMEM_SEL, 12'h000};
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        err_d     = 1'b0;
                    end
                end
                ST_REQ: begin
                    state_d   = ST_WAIT;
                    nread_d   = 1'b1;
                    address_d = '0;
                end
                ST_WAIT: begin
                    if (fetched.opcode == OP_STOP) begin
                        state_d = ST_HALT;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (is_legal_opcode(fetched.opcode)) begin
                        state_d     = ST_PRESENT;
                        valid_d     = 1'b1;
                        instr_d     = fetched;
                        is_matrix_d = is_matrix_opcode(fetched.opcode);
                        pc_out_d    = pc_q;
                    end else begin
                        state_d = ST_ERROR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        if (pc_q == LAST_PC) begin
                            state_d = ST_ERROR;
                            busy_d  = 1'b0;
                            err_d   = 1'b1;
                        end else begin
                            state_d   = ST_REQ;
                            pc_d      = pc_q + 12'd1;
                            nread_d   = 1'b0;
                            address_d = {IMEM_SEL, pc_q + 12'd1};
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            nread_q     <= 1'b1;
            address_q   <= '0;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            is_matrix_q <= 1'b0;
            pc_out_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            nread_q     <= nread_d;
            address_q   <= address_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            is_matrix_q <= is_matrix_d;
            pc_out_q    <= pc_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign address     = address_q;
    assign nRead       = nread_q;
    assign instr_valid = valid_q;
    assign opcode      = instr_q.opcode;
    assign dest        = instr_q.dest;
    assign src1        = instr_q.src1;
    assign src2        = instr_q.src2;
    assign is_matrix   = is_matrix_q;
    assign pc_out      = pc_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer: a default-depth instance plus a
// depth-2 instance for the run-off case, both fed from one program table.
module tb_imem_fetch_sequencer;

    logic         Clk = 1'b0;
    logic         nReset, start, start2, abort, instr_ready;
    logic [255:0] DataIn, DataIn2;
    logic [15:0]  address, address2;
    logic         nRead, nRead2, instr_valid, instr_valid2;
    logic [7:0]   opcode, dest, src1, src2, opcode2, dest2, src1_2, src2_2;
    logic         is_matrix, is_matrix2, busy, busy2, done, done2, err, err2;
    logic [11:0]  pc_out, pc_out2;

    always #5 Clk = ~Clk;

    imem_fetch_sequencer dut (
        .Clk(Clk), .nReset(nReset), .start(start), .abort(abort),
        .address(address), .nRead(nRead), .DataIn(DataIn),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .dest(dest), .src1(src1), .src2(src2),
        .is_matrix(is_matrix), .pc_out(pc_out),
        .busy(busy), .done(done), .err(err)
    );

    imem_fetch_sequencer #(.IMEM_DEPTH(2)) dut2 (
        .Clk(Clk), .nReset(nReset), .start(start2), .abort(abort),
        .address(address2), .nRead(nRead2), .DataIn(DataIn2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready),
        .opcode(opcode2), .dest(dest2), .src1(src1_2), .src2(src2_2),
        .is_matrix(is_matrix2), .pc_out(pc_out2),
        .busy(busy2), .done(done2), .err(err2)
    );

    // memory output settles the cycle after the read strobe
    logic [31:0] prog [0:15];
    always @(posedge Clk) begin
        if (!nRead)  DataIn  <= {224'h0, prog[address[3:0]]};
        if (!nRead2) DataIn2 <= {224'h0, prog[address2[3:0]]};
    end

    logic [15:0] addr_q [$];
    int  rd_viol, v2_cnt;
    logic prev_low, saw8002;
    always @(negedge Clk) begin
        if (!nRead) begin
            addr_q.push_back(address);
            if (prev_low) rd_viol++;
        end
        prev_low = !nRead;
        if (!nRead2 && address2 == 16'h8002) saw8002 = 1'b1;
        if (instr_valid2 && instr_ready) v2_cnt++;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, instr_valid, 1);
    endtask

    logic [7:0] ops [$];
    logic [7:0] dsts [$];
    int seen, stable_bad;

    initial begin
        nReset = 1'b0; start = 1'b0; start2 = 1'b0; abort = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;
        prog[0] = 32'h01_02_00_01;
        prog[1] = 32'h02_03_00_01;
        prog[2] = 32'hFF_FF_FF_FF;
        tick(); tick();
        chk("rst_nread", nRead, 1);
        chk("rst_addr", address, 16'h0000);
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        nReset = 1'b1;
        tick();
        addr_q.delete();
        rd_viol = 0;

        // program runs to Stop with ready high
        pulse_start();
        chk("t1_req_nread", nRead, 0);
        chk("t1_req_addr", address, 16'h8000);
        chk("t1_req_busy", busy, 1);
        tick();
        chk("t1_wait_nread", nRead, 1);
        chk("t1_wait_addr", address, 16'h0000);
        ops.delete(); dsts.delete();
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (instr_valid) begin
                ops.push_back(opcode);
                dsts.push_back(dest);
            end
        end
        chk("t1_npres", ops.size(), 2);
        if (ops.size() == 2) begin
            chk("t1_op0", ops[0], 8'h01);
            chk("t1_dst0", dsts[0], 8'h02);
            chk("t1_op1", ops[1], 8'h02);
            chk("t1_dst1", dsts[1], 8'h03);
        end
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_busy", busy, 0);
        chk("t1_pc_out", pc_out, 1);
        chk("t1_nreads", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            chk("t1_addr0", addr_q[0], 16'h8000);
            chk("t1_addr1", addr_q[1], 16'h8001);
            chk("t1_addr2", addr_q[2], 16'h8002);
        end

        // stall the first instruction for 5 cycles, restarting from HALT
        instr_ready = 1'b0;
        addr_q.delete();
        pulse_start();
        chk("t2_done_clr", done, 0);
        wait_valid("t2_valid");
        stable_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!instr_valid || opcode != 8'h01 || dest != 8'h02 || src2 != 8'h01 || pc_out != 0)
                stable_bad++;
        end
        chk("t2_stable", stable_bad, 0);
        chk("t2_no_refetch", addr_q.size(), 1);
        instr_ready = 1'b1;
        ops.delete();
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (instr_valid) ops.push_back(opcode);
        end
        chk("t2_npres", ops.size(), 1);
        if (ops.size() == 1) chk("t2_op1", ops[0], 8'h02);
        chk("t2_done", done, 1);
        chk("t2_nreads", addr_q.size(), 3);

        // illegal opcode, then restart clears err
        prog[0] = 32'h07_00_00_00;
        pulse_start();
        seen = 0;
        for (int i = 0; i < 10 && !err; i++) begin
            tick();
            if (instr_valid) seen++;
        end
        chk("t3_err", err, 1);
        chk("t3_done", done, 0);
        chk("t3_no_valid", seen, 0);
        chk("t3_busy", busy, 0);
        prog[0] = 32'h01_02_00_01;
        instr_ready = 1'b0;
        pulse_start();
        chk("t3_err_clr", err, 0);
        chk("t3_refetch_addr", address, 16'h8000);
        wait_valid("t3_valid");
        chk("t3_opcode", opcode, 8'h01);
        chk("t3_is_matrix", is_matrix, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t3_abort_valid", instr_valid, 0);

        // abort in WAIT while start is also high
        pulse_start();
        tick();
        chk("t4_in_wait", nRead, 1);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_nread", nRead, 1);
        chk("t4_valid", instr_valid, 0);
        chk("t4_addr", address, 16'h0000);
        tick(); tick(); tick();
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_valid", instr_valid, 0);
        pulse_start();
        chk("t4_pc0_addr", address, 16'h8000);
        abort = 1'b1; tick(); abort = 1'b0;

        // reset while presenting
        pulse_start();
        wait_valid("t5_valid");
        nReset = 1'b0;
        tick();
        nReset = 1'b1;
        chk("t5_valid", instr_valid, 0);
        chk("t5_nread", nRead, 1);
        chk("t5_addr", address, 16'h0000);
        chk("t5_fields", {opcode, dest, src1, src2}, 32'h0);
        chk("t5_is_matrix", is_matrix, 0);
        chk("t5_flags", {busy, done, err}, 3'b000);
        pulse_start();
        chk("t5_restart_addr", address, 16'h8000);
        chk("t5_restart_nread", nRead, 0);
        abort = 1'b1; tick(); abort = 1'b0;

        // run-off past a 2-word program
        prog[2] = 32'h03_00_00_00;
        instr_ready = 1'b1;
        saw8002 = 1'b0;
        v2_cnt = 0;
        start2 = 1'b1; tick(); start2 = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t6_err", err2, 1);
        chk("t6_done", done2, 0);
        chk("t6_busy", busy2, 0);
        chk("t6_handshakes", v2_cnt, 2);
        chk("t6_no_8002", saw8002, 0);
        chk("t6_pc_out", pc_out2, 1);

        chk("nread_consec", rd_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
